// File: rtl/out_requant_packer.sv
// out_requant_packer: requantises 32-bit signed MAC accumulations to 16-bit
// signed lanes and packs them three at a time into a small group FIFO.
// The 3-lane groups are released through a valid/ready output.
// A flush command emits a trailing partial group.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where both
// valid and ready are high. acc_ready is computed from registered state
// only. out_valid/out_1..3/out_count show the FIFO head combinationally,
// and a pop happens when out_valid && out_ready.
module out_requant_packer #(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FIFO_DEPTH         = 4,
  parameter int SHIFT_WIDTH        = 5
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic [ACCUMULATION_WIDTH-1:0] acc_in,
  input  logic                          acc_valid,
  output logic                          acc_ready,
  input  logic [SHIFT_WIDTH-1:0]        shift_amt,
  input  logic                          flush,
  output logic [IO_DATA_WIDTH-1:0]      out_1,
  output logic [IO_DATA_WIDTH-1:0]      out_2,
  output logic [IO_DATA_WIDTH-1:0]      out_3,
  output logic [1:0]                    out_count,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int AW = ACCUMULATION_WIDTH;
  localparam int DW = IO_DATA_WIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic signed [AW:0] SAT_MAX = {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW:0] SAT_MIN = {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};

  // Requant stage register
  logic                   s1_valid;
  logic [DW-1:0]          s1_data;
  // Packer state: two held lanes and the next lane index
  logic [DW-1:0]          lane0, lane1;
  logic [1:0]             lane_cnt;
  logic                   flush_pend;
  // Group FIFO
  logic [DW-1:0]          mem_l0 [FIFO_DEPTH];
  logic [DW-1:0]          mem_l1 [FIFO_DEPTH];
  logic [DW-1:0]          mem_l2 [FIFO_DEPTH];
  logic [1:0]             mem_cnt[FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;

  logic                   accept, push, pop, full, flush_do;
  logic [DW-1:0]          push_l0, push_l1, push_l2;
  logic [1:0]             push_cnt;
  logic [SHIFT_WIDTH-1:0] s_clamped;
  logic signed [AW:0]     acc_ext, rnd, sum, shifted;
  logic [DW-1:0]          req_val;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign acc_ready = (count <= CW'(FIFO_DEPTH - 2)) && !flush_pend;
  assign accept    = acc_valid && acc_ready;
  assign pop       = out_valid && out_ready;
  // A flush completes only once the requant stage has drained into the lanes
  assign flush_do  = flush_pend && !s1_valid && !full;
  assign busy      = s1_valid || (lane_cnt != 2'd0) || out_valid || flush_pend;

  // Rounding arithmetic right shift in AW+1 bits, then saturate to DW bits
  always_comb begin
    s_clamped = shift_amt;
    if (int'(shift_amt) > AW - 1) s_clamped = SHIFT_WIDTH'(AW - 1);
    acc_ext = {acc_in[AW-1], acc_in};
    rnd     = '0;
    if (s_clamped != '0) rnd = (AW+1)'(1) << (s_clamped - SHIFT_WIDTH'(1));
    sum     = acc_ext + rnd;
    shifted = sum >>> s_clamped;
    if (shifted > SAT_MAX)      req_val = SAT_MAX[DW-1:0];
    else if (shifted < SAT_MIN) req_val = SAT_MIN[DW-1:0];
    else                        req_val = shifted[DW-1:0];
  end

  // Select what gets pushed: a completed 3-lane group or a flushed partial one
  always_comb begin
    push     = 1'b0;
    push_l0  = lane0;
    push_l1  = lane1;
    push_l2  = s1_data;
    push_cnt = 2'd3;
    if (s1_valid && lane_cnt == 2'd2) begin
      push = 1'b1;
    end else if (flush_do && lane_cnt != 2'd0) begin
      push     = 1'b1;
      push_l1  = (lane_cnt == 2'd2) ? lane1 : '0;
      push_l2  = '0;
      push_cnt = lane_cnt;
    end
  end

  // Requant register, packer lanes and flush bookkeeping
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      lane0      <= '0;
      lane1      <= '0;
      lane_cnt   <= 2'd0;
      flush_pend <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_data <= req_val;
      if (s1_valid) begin
        if (lane_cnt == 2'd0) lane0 <= s1_data;
        if (lane_cnt == 2'd1) lane1 <= s1_data;
        lane_cnt <= (lane_cnt == 2'd2) ? 2'd0 : lane_cnt + 2'd1;
      end else if (flush_do) begin
        lane_cnt <= 2'd0;
      end
      if (flush_do)   flush_pend <= 1'b0;
      else if (flush) flush_pend <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; a push with a pop leaves count unchanged
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are never visible while the entry is unoccupied
  always_ff @(posedge clk) begin
    if (push) begin
      mem_l0[wr_ptr]  <= push_l0;
      mem_l1[wr_ptr]  <= push_l1;
      mem_l2[wr_ptr]  <= push_l2;
      mem_cnt[wr_ptr] <= push_cnt;
    end
  end

  // Head of FIFO, forced to zero when empty
  always_comb begin
    out_1     = '0;
    out_2     = '0;
    out_3     = '0;
    out_count = 2'd0;
    if (out_valid) begin
      out_1     = mem_l0[rd_ptr];
      out_2     = mem_l1[rd_ptr];
      out_3     = mem_l2[rd_ptr];
      out_count = mem_cnt[rd_ptr];
    end
  end

endmodule

// File: tb/tb_out_requant_packer.sv
// Bench for out_requant_packer: table of requant vectors, random samples,
// and hand-written sequences for backpressure, flush and mid-stream reset.
module tb_out_requant_packer;

  logic        clk;
  logic        arst_n_in;
  logic [31:0] acc_in;
  logic        acc_valid;
  logic        acc_ready;
  logic [4:0]  shift_amt;
  logic        flush;
  logic [15:0] out_1, out_2, out_3;
  logic [1:0]  out_count;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Expected group: {count[49:48], lane0[47:32], lane1[31:16], lane2[15:0]}
  logic [49:0] exp_q[$];
  logic [15:0] m_lane[3];
  int          m_cnt = 0;

  typedef struct {
    logic [31:0] acc;
    logic [4:0]  sh;
    logic [15:0] exp_v;
  } vec_t;
  vec_t vecs[12];

  out_requant_packer dut (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .acc_in    (acc_in),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .shift_amt (shift_amt),
    .flush     (flush),
    .out_1     (out_1),
    .out_2     (out_2),
    .out_3     (out_3),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Independent requant model using 64-bit arithmetic
  function automatic logic [15:0] model_rq(input logic [31:0] a, input logic [4:0] sh);
    longint v;
    int     s;
    v = longint'($signed(a));
    s = int'(sh);
    if (s > 31) s = 31;
    if (s > 0) v = v + (longint'(1) << (s - 1));
    v = v >>> s;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic model_accept(input logic [15:0] v);
    m_lane[m_cnt] = v;
    m_cnt++;
    if (m_cnt == 3) begin
      exp_q.push_back({2'd3, m_lane[0], m_lane[1], m_lane[2]});
      m_cnt = 0;
    end
  endtask

  // Driver: hold a sample until accepted (called at posedge+1, returns at posedge+1)
  task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic [15:0] expv);
    logic got;
    got       = 1'b0;
    acc_in    = d;
    shift_amt = sh;
    acc_valid = 1'b1;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (acc_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    acc_valid = 1'b0;
    chk("send_accept", got, 1'b1);
    if (got) model_accept(expv);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    if (m_cnt > 0) begin
      exp_q.push_back({2'(m_cnt), m_lane[0], (m_cnt > 1) ? m_lane[1] : 16'h0, 16'h0});
      m_cnt = 0;
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 200 && (exp_q.size() != 0 || busy); c++) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_queue_empty"}, 64'(exp_q.size()), 0);
    chk({name, "_busy"}, busy, 1'b0);
  endtask

  // Scoreboard: compare the head group on the negedge before it is popped
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_group: got cnt=%0d %0h %0h %0h expected none",
                 out_count, out_1, out_2, out_3);
      end else begin
        logic [49:0] e;
        e = exp_q.pop_front();
        chk("grp_count", out_count, e[49:48]);
        chk("grp_lane0", out_1, e[47:32]);
        chk("grp_lane1", out_2, e[31:16]);
        chk("grp_lane2", out_3, e[15:0]);
      end
    end
  end

  initial begin
    int   idx;
    logic take;
    logic [31:0] r;
    logic [4:0]  rs;

    vecs[0]  = '{32'd5,          5'd0,  16'd5};
    vecs[1]  = '{-32'sd7,        5'd0,  -16'sd7};
    vecs[2]  = '{32'd100,        5'd0,  16'd100};
    vecs[3]  = '{32'd24,         5'd4,  16'd2};
    vecs[4]  = '{-32'sd24,       5'd4,  -16'sd1};
    vecs[5]  = '{32'd23,         5'd4,  16'd1};
    vecs[6]  = '{32'd40000,      5'd0,  16'h7FFF};
    vecs[7]  = '{-32'sd40000,    5'd0,  16'h8000};
    vecs[8]  = '{32'd32767,      5'd0,  16'h7FFF};
    vecs[9]  = '{32'h7FFF_FFFF,  5'd31, 16'd1};
    vecs[10] = '{-32'sd1,        5'd1,  16'd0};
    vecs[11] = '{32'd3,          5'd1,  16'd2};

    // Reset
    arst_n_in = 1'b0;
    acc_in    = '0;
    acc_valid = 1'b0;
    shift_amt = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n_in = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_count", out_count, 2'd0);
    chk("rst_acc_ready", acc_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_1", out_1, 16'd0);

    // Table-driven requant/pack, with latency check on the first group
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].acc, vecs[i].sh, vecs[i].exp_v);
      if (i == 2) begin
        chk("lat_edge_k", out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("lat_edge_k1", out_valid, 1'b1);
      end
    end
    wait_drain("table");

    // Random samples against the model
    for (int i = 0; i < 6; i++) begin
      r  = $urandom();
      rs = 5'($urandom_range(0, 31));
      send(r, rs, model_rq(r, rs));
    end
    wait_drain("random");

    // Backpressure: the ninth sample's group lands one edge after it is
    // accepted, so the registered count still shows two free entries and the
    // tenth sample is taken before acc_ready drops.
    out_ready = 1'b0;
    acc_valid = 1'b1;
    shift_amt = 5'd0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      acc_in = 32'(1000 + idx);
      @(negedge clk);
      take = acc_ready;
      @(posedge clk);
      #1;
      if (take) begin
        model_accept(16'(1000 + idx));
        idx++;
      end
    end
    acc_valid = 1'b0;
    chk("bp_accepted", 64'(idx), 64'd10);
    chk("bp_acc_ready", acc_ready, 1'b0);
    chk("bp_busy", busy, 1'b1);
    out_ready = 1'b1;
    do_flush();
    wait_drain("bp");

    // Flush a partial group, then a flush with nothing held
    send(32'd1, 5'd0, 16'd1);
    send(32'd2, 5'd0, 16'd2);
    do_flush();
    chk("flush_busy", busy, 1'b1);
    wait_drain("flush");
    do_flush();
    repeat (5) @(posedge clk);
    #1;
    chk("empty_flush_busy", busy, 1'b0);
    chk("empty_flush_valid", out_valid, 1'b0);

    // Reset mid-stream with two groups queued and one lane held
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(32'(50 + i), 5'd0, 16'(50 + i));
    @(posedge clk);
    #1;
    chk("pre_rst_valid", out_valid, 1'b1);
    #2;
    arst_n_in = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_count", out_count, 2'd0);
    chk("mid_rst_lanes", {out_1, out_2, out_3}, 48'd0);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    arst_n_in = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_acc_ready", acc_ready, 1'b1);
    out_ready = 1'b1;
    send(32'd7, 5'd0, 16'd7);
    send(32'd8, 5'd0, 16'd8);
    send(32'd9, 5'd0, 16'd9);
    wait_drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
